hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage RV32 core. It handles the hazards that EX-stage operand forwarding cannot resolve.
- It raises a one-cycle load-use stall, flushes IF/ID and ID/EX on a taken branch, and freezes the pipe while data memory is not ready.
- A stall-cycle counter and a memory-timeout watchdog latch a sticky error and halt the core.
- It sits beside the forwarding unit and drives the PC and pipeline-register hold/flush/bubble controls.

---
 rtl/hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: load-use stall, branch flush, memory-wait freeze, watchdog
//
// Purpose:
//   Generates the PC and pipeline-register hold/flush/bubble controls for the
//   5-stage RV32 core. It covers the hazards that EX-stage operand forwarding
//   cannot resolve. A memory-wait watchdog latches a sticky error and halts
//   the core. A saturating counter records every cycle in which the PC is held.
//
// Ports:
//   clk, rst                   clock (rising edge), asynchronous active-high reset
//   ID_rs1/ID_rs2              source registers of the instruction in ID
//   ID_use_rs1/ID_use_rs2      the ID instruction actually reads that source
//   EX_rd, EX_memrd            destination register of the EX instruction, and whether it is a load
//   EX_brtaken                 EX resolved a taken branch or jump
//   MEM_memreq, MEM_ready      MEM-stage data memory request and its completion
//   PC_hold .. MEMWB_bubble    combinational pipeline controls
//   mem_timeout                sticky watchdog error
//   stall_cycles               saturating count of cycles with PC_hold=1

module hazard_ctrl #(
   parameter int num_width = 5,
   parameter int TIMEOUT   = 16,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [num_width-1:0] ID_rs1,
   input  logic [num_width-1:0] ID_rs2,
   input  logic                 ID_use_rs1,
   input  logic                 ID_use_rs2,
   input  logic [num_width-1:0] EX_rd,
   input  logic                 EX_memrd,
   input  logic                 EX_brtaken,
   input  logic                 MEM_memreq,
   input  logic                 MEM_ready,
   output logic                 PC_hold,
   output logic                 IFID_hold,
   output logic                 IFID_flush,
   output logic                 IDEX_hold,
   output logic                 IDEX_bubble,
   output logic                 EXMEM_hold,
   output logic                 MEMWB_bubble,
   output logic                 mem_timeout,
   output logic [CNT_W-1:0]     stall_cycles
);

   // The wait counter only has to reach TIMEOUT-1.
   localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      MWAIT = 2'd1,
      HALT  = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [WW-1:0]   wait_cnt, wait_cnt_nxt;
   logic            timeout_nxt;
   logic            memstall;
   logic            loaduse;

   assign memstall = MEM_memreq & ~MEM_ready;

   // x0 is hardwired to zero, so a load into x0 never creates a dependency.
   assign loaduse = EX_memrd & (EX_rd != '0) &
                    ((ID_use_rs1 & (ID_rs1 == EX_rd)) |
                     (ID_use_rs2 & (ID_rs2 == EX_rd)));

   // Pipeline controls: zero latency from the inputs and the current state.
   // They are forced low while reset is asserted.
   always_comb begin
      PC_hold      = 1'b0;
      IFID_hold    = 1'b0;
      IFID_flush   = 1'b0;
      IDEX_hold    = 1'b0;
      IDEX_bubble  = 1'b0;
      EXMEM_hold   = 1'b0;
      MEMWB_bubble = 1'b0;
      if (!rst) begin
         if (state == HALT || memstall) begin
            // Freeze everything up to MEM. A pending branch or load-use stays
            // in EX and ID, so it is serviced once memory is ready.
            PC_hold      = 1'b1;
            IFID_hold    = 1'b1;
            IDEX_hold    = 1'b1;
            EXMEM_hold   = 1'b1;
            MEMWB_bubble = 1'b1;
         end else if (EX_brtaken) begin
            // The ID instruction is squashed, so a load-use hazard is irrelevant.
            IFID_flush  = 1'b1;
            IDEX_bubble = 1'b1;
         end else if (loaduse) begin
            // One cycle only: the inserted nop moves into EX and clears loaduse.
            PC_hold     = 1'b1;
            IFID_hold   = 1'b1;
            IDEX_bubble = 1'b1;
         end
      end
   end

   // Next-state logic for the memory-wait watchdog.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      timeout_nxt  = mem_timeout;
      case (state)
         RUN: begin
            if (memstall) begin
               // The first not-ready cycle already counts toward the timeout.
               state_nxt    = MWAIT;
               wait_cnt_nxt = WW'(1);
            end
         end
         MWAIT: begin
            if (!memstall) begin
               // Covers MEM_ready and also a request that is withdrawn.
               state_nxt    = RUN;
               wait_cnt_nxt = '0;
            end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
               state_nxt   = HALT;
               timeout_nxt = 1'b1;
            end else begin
               wait_cnt_nxt = wait_cnt + WW'(1);
            end
         end
         HALT: begin
            state_nxt = HALT;
         end
         default: begin
            state_nxt    = RUN;
            wait_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= RUN;
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else begin
         state       <= state_nxt;
         wait_cnt    <= wait_cnt_nxt;
         mem_timeout <= timeout_nxt;
      end
   end

   // Saturating counter of PC-held cycles. HALT cycles are included.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles <= '0;
      end else if (PC_hold && (stall_cycles != {CNT_W{1'b1}})) begin
         stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl

module tb_hazard_ctrl;

   // Control vector order: {PC_hold, IFID_hold, IFID_flush, IDEX_hold, IDEX_bubble, EXMEM_hold, MEMWB_bubble}
   localparam logic [6:0] C_NONE  = 7'b0000000;
   localparam logic [6:0] C_FREEZE = 7'b1101011;
   localparam logic [6:0] C_FLUSH = 7'b0010100;
   localparam logic [6:0] C_LU    = 7'b1100100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] ID_rs1 = '0, ID_rs2 = '0, EX_rd = '0;
   logic       ID_use_rs1 = 0, ID_use_rs2 = 0, EX_memrd = 0, EX_brtaken = 0;
   logic       MEM_memreq = 0, MEM_ready = 0;

   logic [6:0]  ctl_a, ctl_b, ctl_c;
   logic        to_a, to_b, to_c;
   logic [15:0] sc_a, sc_b;
   logic [2:0]  sc_c;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // Instance a: default parameters.
   hazard_ctrl #(.num_width(5), .TIMEOUT(16), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
      .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2), .EX_rd(EX_rd),
      .EX_memrd(EX_memrd), .EX_brtaken(EX_brtaken), .MEM_memreq(MEM_memreq),
      .MEM_ready(MEM_ready), .PC_hold(ctl_a[6]), .IFID_hold(ctl_a[5]),
      .IFID_flush(ctl_a[4]), .IDEX_hold(ctl_a[3]), .IDEX_bubble(ctl_a[2]),
      .EXMEM_hold(ctl_a[1]), .MEMWB_bubble(ctl_a[0]), .mem_timeout(to_a),
      .stall_cycles(sc_a));

   // Instance b: short watchdog.
   hazard_ctrl #(.num_width(5), .TIMEOUT(4), .CNT_W(16)) dut_b (
      .clk(clk), .rst(rst), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
      .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2), .EX_rd(EX_rd),
      .EX_memrd(EX_memrd), .EX_brtaken(EX_brtaken), .MEM_memreq(MEM_memreq),
      .MEM_ready(MEM_ready), .PC_hold(ctl_b[6]), .IFID_hold(ctl_b[5]),
      .IFID_flush(ctl_b[4]), .IDEX_hold(ctl_b[3]), .IDEX_bubble(ctl_b[2]),
      .EXMEM_hold(ctl_b[1]), .MEMWB_bubble(ctl_b[0]), .mem_timeout(to_b),
      .stall_cycles(sc_b));

   // Instance c: narrow stall counter.
   hazard_ctrl #(.num_width(5), .TIMEOUT(16), .CNT_W(3)) dut_c (
      .clk(clk), .rst(rst), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
      .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2), .EX_rd(EX_rd),
      .EX_memrd(EX_memrd), .EX_brtaken(EX_brtaken), .MEM_memreq(MEM_memreq),
      .MEM_ready(MEM_ready), .PC_hold(ctl_c[6]), .IFID_hold(ctl_c[5]),
      .IFID_flush(ctl_c[4]), .IDEX_hold(ctl_c[3]), .IDEX_bubble(ctl_c[2]),
      .EXMEM_hold(ctl_c[1]), .MEMWB_bubble(ctl_c[0]), .mem_timeout(to_c),
      .stall_cycles(sc_c));

   task automatic clear_inputs();
      ID_rs1 = '0; ID_rs2 = '0; EX_rd = '0;
      ID_use_rs1 = 0; ID_use_rs2 = 0; EX_memrd = 0; EX_brtaken = 0;
      MEM_memreq = 0; MEM_ready = 0;
   endtask

   // Leaves the bench 1 time unit after a rising edge, with reset released.
   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      MEM_memreq = 1; MEM_ready = 0; EX_brtaken = 1;
      @(posedge clk); #2;
      n_cmp++;
      if (ctl_a !== C_NONE) begin
         n_err++; $display("FAIL reset_ctl: got %b want %b", ctl_a, C_NONE);
      end
      n_cmp++;
      if (sc_a !== 16'd0 || to_a !== 1'b0) begin
         n_err++; $display("FAIL reset_regs: got sc=%0d to=%b want sc=0 to=0", sc_a, to_a);
      end
      do_reset();
   endtask

   task automatic test_loaduse();
      do_reset();
      EX_memrd = 1; EX_rd = 5'd5; ID_rs2 = 5'd5; ID_use_rs2 = 1;
      #1;
      n_cmp++;
      if (ctl_a !== C_LU) begin
         n_err++; $display("FAIL loaduse_ctl: got %b want %b", ctl_a, C_LU);
      end
      next_cycle();
      EX_memrd = 0;
      #1;
      n_cmp++;
      if (ctl_a !== C_NONE) begin
         n_err++; $display("FAIL loaduse_one_cycle: got %b want %b", ctl_a, C_NONE);
      end
      n_cmp++;
      if (sc_a !== 16'd1) begin
         n_err++; $display("FAIL loaduse_count: got %0d want 1", sc_a);
      end
   endtask

   task automatic test_x0_unused();
      do_reset();
      EX_memrd = 1; EX_rd = 5'd0; ID_rs1 = 5'd0; ID_use_rs1 = 1;
      #1;
      n_cmp++;
      if (ctl_a !== C_NONE) begin
         n_err++; $display("FAIL x0_no_stall: got %b want %b", ctl_a, C_NONE);
      end
      next_cycle();
      EX_rd = 5'd7; ID_rs1 = 5'd7; ID_use_rs1 = 0;
      #1;
      n_cmp++;
      if (ctl_a !== C_NONE) begin
         n_err++; $display("FAIL unused_no_stall: got %b want %b", ctl_a, C_NONE);
      end
      next_cycle();
      n_cmp++;
      if (sc_a !== 16'd0) begin
         n_err++; $display("FAIL x0_count: got %0d want 0", sc_a);
      end
   endtask

   task automatic test_branch_loaduse();
      do_reset();
      EX_memrd = 1; EX_rd = 5'd9; ID_rs1 = 5'd9; ID_use_rs1 = 1; EX_brtaken = 1;
      #1;
      n_cmp++;
      if (ctl_a !== C_FLUSH) begin
         n_err++; $display("FAIL branch_ctl: got %b want %b", ctl_a, C_FLUSH);
      end
      next_cycle();
      n_cmp++;
      if (sc_a !== 16'd0) begin
         n_err++; $display("FAIL branch_count: got %0d want 0", sc_a);
      end
   endtask

   task automatic test_mem_wait();
      do_reset();
      MEM_memreq = 1; MEM_ready = 0; EX_brtaken = 1;
      EX_memrd = 1; EX_rd = 5'd3; ID_rs1 = 5'd3; ID_use_rs1 = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if (ctl_a !== C_FREEZE) begin
            n_err++; $display("FAIL memwait_freeze[%0d]: got %b want %b", i, ctl_a, C_FREEZE);
         end
         next_cycle();
      end
      MEM_ready = 1;
      #1;
      n_cmp++;
      if (ctl_a !== C_FLUSH) begin
         n_err++; $display("FAIL memwait_ready: got %b want %b", ctl_a, C_FLUSH);
      end
      next_cycle();
      n_cmp++;
      if (sc_a !== 16'd3) begin
         n_err++; $display("FAIL memwait_count: got %0d want 3", sc_a);
      end
      clear_inputs();
      #1;
      n_cmp++;
      if (ctl_a !== C_NONE) begin
         n_err++; $display("FAIL memwait_back_to_run: got %b want %b", ctl_a, C_NONE);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      MEM_memreq = 1; MEM_ready = 0;
      for (int i = 1; i <= 6; i++) begin
         #1;
         n_cmp++;
         if (ctl_b !== C_FREEZE) begin
            n_err++; $display("FAIL timeout_freeze[%0d]: got %b want %b", i, ctl_b, C_FREEZE);
         end
         next_cycle();
         n_cmp++;
         if (to_b !== (i >= 4)) begin
            n_err++; $display("FAIL timeout_flag[%0d]: got %b want %b", i, to_b, (i >= 4));
         end
      end
      MEM_ready = 1;
      #1;
      n_cmp++;
      if (ctl_b !== C_FREEZE) begin
         n_err++; $display("FAIL halt_holds: got %b want %b", ctl_b, C_FREEZE);
      end
      n_cmp++;
      if (ctl_a !== C_NONE || to_a !== 1'b0) begin
         n_err++; $display("FAIL no_halt_default: got ctl=%b to=%b want ctl=%b to=0", ctl_a, to_a, C_NONE);
      end
      next_cycle();
      n_cmp++;
      if (sc_b !== 16'd7) begin
         n_err++; $display("FAIL halt_count: got %0d want 7", sc_b);
      end
      #3;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (ctl_b !== C_NONE || sc_b !== 16'd0 || to_b !== 1'b0) begin
         n_err++; $display("FAIL halt_reset: got ctl=%b sc=%0d to=%b want ctl=0 sc=0 to=0", ctl_b, sc_b, to_b);
      end
      do_reset();
   endtask

   task automatic test_saturation();
      do_reset();
      MEM_memreq = 1; MEM_ready = 0;
      for (int i = 1; i <= 9; i++) begin
         next_cycle();
         n_cmp++;
         if (sc_c !== 3'((i > 7) ? 7 : i)) begin
            n_err++; $display("FAIL sat_count[%0d]: got %0d want %0d", i, sc_c, (i > 7) ? 7 : i);
         end
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_loaduse();
      test_x0_unused();
      test_branch_loaduse();
      test_mem_wait();
      test_timeout();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
